// File: rtl/des_pkg.sv
// Shared DES key-schedule types and tables. All tables hold 0-based bit indices
// into ascending vectors, where index 0 is DES bit 1.
package des_pkg;

  localparam int KEY_W  = 32'd64;
  localparam int CD_W   = 32'd56;
  localparam int HALF_W = 32'd28;
  localparam int SK_W   = 32'd48;

  typedef logic [0:63] des_key_t;
  typedef logic [0:55] des_cd_t;
  typedef logic [0:47] des_subkey_t;

  typedef enum logic {
    KS_IDLE = 1'b0,
    KS_EMIT = 1'b1
  } ks_state_e;

  localparam logic [5:0] PC1_TABLE [CD_W] = '{
    6'd56, 6'd48, 6'd40, 6'd32, 6'd24, 6'd16, 6'd8,
    6'd0,  6'd57, 6'd49, 6'd41, 6'd33, 6'd25, 6'd17,
    6'd9,  6'd1,  6'd58, 6'd50, 6'd42, 6'd34, 6'd26,
    6'd18, 6'd10, 6'd2,  6'd59, 6'd51, 6'd43, 6'd35,
    6'd62, 6'd54, 6'd46, 6'd38, 6'd30, 6'd22, 6'd14,
    6'd6,  6'd61, 6'd53, 6'd45, 6'd37, 6'd29, 6'd21,
    6'd13, 6'd5,  6'd60, 6'd52, 6'd44, 6'd36, 6'd28,
    6'd20, 6'd12, 6'd4,  6'd27, 6'd19, 6'd11, 6'd3
  };

  localparam logic [5:0] PC2_TABLE [SK_W] = '{
    6'd13, 6'd16, 6'd10, 6'd23, 6'd0,  6'd4,
    6'd2,  6'd27, 6'd14, 6'd5,  6'd20, 6'd9,
    6'd22, 6'd18, 6'd11, 6'd3,  6'd25, 6'd7,
    6'd15, 6'd6,  6'd26, 6'd19, 6'd12, 6'd1,
    6'd40, 6'd51, 6'd30, 6'd36, 6'd46, 6'd54,
    6'd29, 6'd39, 6'd50, 6'd44, 6'd32, 6'd47,
    6'd43, 6'd48, 6'd38, 6'd55, 6'd33, 6'd52,
    6'd45, 6'd41, 6'd49, 6'd35, 6'd28, 6'd31
  };

  // Entry r-1 is the rotation amount of round r.
  localparam logic [1:0] KS_SHIFT [16] = '{
    2'd1, 2'd1, 2'd2, 2'd2, 2'd2, 2'd2, 2'd2, 2'd2,
    2'd1, 2'd2, 2'd2, 2'd2, 2'd2, 2'd2, 2'd2, 2'd1
  };

  // High when any key byte carries even parity (DES expects odd parity per byte).
  function automatic logic key_parity_bad(input des_key_t k);
    return (~^k[0:7])   | (~^k[8:15])  | (~^k[16:23]) | (~^k[24:31]) |
           (~^k[32:39]) | (~^k[40:47]) | (~^k[48:55]) | (~^k[56:63]);
  endfunction

endpackage

// File: rtl/des_key_schedule_dec_if.sv
// Key-in / subkey-out handshake bundle of the DES decryption key schedule.
// master = key source and subkey consumer, slave = the key schedule block.
interface des_key_schedule_dec_if;

  des_pkg::des_key_t    key_in;
  logic                 key_valid;
  logic                 key_ready;
  des_pkg::des_subkey_t subkey;
  logic [3:0]           subkey_idx;
  logic                 subkey_valid;
  logic                 subkey_ready;
  logic                 key_parity_err;

  modport master (
    output key_in, key_valid, subkey_ready,
    input  key_ready, subkey, subkey_idx, subkey_valid, key_parity_err
  );

  modport slave (
    input  key_in, key_valid, subkey_ready,
    output key_ready, subkey, subkey_idx, subkey_valid, key_parity_err
  );

endinterface

// File: rtl/des_pc2.sv
// DES permuted choice 2: selects the 48 subkey bits from the 56-bit C/D state.
module des_pc2
  import des_pkg::*;
(
  input  des_cd_t     cd_i,
  output des_subkey_t subkey_o
);

  for (genvar g = 0; g < SK_W; g++) begin : g_pc2
    assign subkey_o[g] = cd_i[PC2_TABLE[g]];
  end

endmodule

// File: rtl/des_key_schedule_dec.sv
// Iterative DES decryption key schedule: emits K16 down to K1, one per subkey handshake.
// Optional build macro DES_KS_PARITY_CHECK_EN adds the per-byte key parity check.
module des_key_schedule_dec
  import des_pkg::*;
(
  input  logic                   clk,
  input  logic                   rst,
  des_key_schedule_dec_if.slave  ks
);

  ks_state_e  state_q;
  des_cd_t    cd_q;
  logic [3:0] idx_q;

  des_cd_t    pc1_s;
  des_cd_t    cd_rot_s;
  logic       key_hs_s;
  logic       sub_hs_s;

  for (genvar g = 0; g < CD_W; g++) begin : g_pc1
    assign pc1_s[g] = ks.key_in[PC1_TABLE[g]];
  end

  assign key_hs_s = ks.key_valid & ks.key_ready;
  assign sub_hs_s = ks.subkey_valid & ks.subkey_ready;

  // Undo the round's left shift: rotate C and D right by the amount of round idx+1.
  always_comb begin
    case (KS_SHIFT[idx_q])
      2'd1:    cd_rot_s = {cd_q[27],    cd_q[0:26], cd_q[55],    cd_q[28:54]};
      2'd2:    cd_rot_s = {cd_q[26:27], cd_q[0:25], cd_q[54:55], cd_q[28:53]};
      default: cd_rot_s = cd_q;
    endcase
  end

  // Schedule FSM: load PC-1 on key accept, step the C/D state on each subkey taken.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= KS_IDLE;
      cd_q    <= '0;
      idx_q   <= 4'd0;
    end else begin
      case (state_q)
        KS_IDLE: begin
          if (key_hs_s) begin
            state_q <= KS_EMIT;
            cd_q    <= pc1_s;
            idx_q   <= 4'd15;
          end else begin
            state_q <= KS_IDLE;
          end
        end
        KS_EMIT: begin
          if (sub_hs_s) begin
            if (idx_q == 4'd0) begin
              state_q <= KS_IDLE;
            end else begin
              cd_q  <= cd_rot_s;
              idx_q <= idx_q - 4'd1;
            end
          end else begin
            state_q <= KS_EMIT;
          end
        end
        default: begin
          state_q <= KS_IDLE;
        end
      endcase
    end
  end

  // key_ready is masked by rst so a key offered during reset is never taken.
  assign ks.key_ready    = (state_q == KS_IDLE) & ~rst;
  assign ks.subkey_valid = (state_q == KS_EMIT);
  assign ks.subkey_idx   = idx_q;

  des_pc2 u_pc2 (
    .cd_i     (cd_q),
    .subkey_o (ks.subkey)
  );

`ifdef DES_KS_PARITY_CHECK_EN
  logic key_parity_err_q;

  // Capture the parity verdict of the accepted key; it holds until the next key.
  always_ff @(posedge clk) begin
    if (rst) begin
      key_parity_err_q <= 1'b0;
    end else if (key_hs_s) begin
      key_parity_err_q <= key_parity_bad(ks.key_in);
    end else begin
      key_parity_err_q <= key_parity_err_q;
    end
  end

  assign ks.key_parity_err = key_parity_err_q;
`else
  logic unused_parity_bits_s;

  assign ks.key_parity_err   = 1'b0;
  assign unused_parity_bits_s = ^{ks.key_in[7],  ks.key_in[15], ks.key_in[23], ks.key_in[31],
                                  ks.key_in[39], ks.key_in[47], ks.key_in[55], ks.key_in[63]};
`endif

endmodule

// File: tb/tb_des_key_schedule_dec.sv
// Scoreboard bench for des_key_schedule_dec: an independent forward DES key
// schedule model fills the expected queue in decryption order at each key accept.
module tb_des_key_schedule_dec;

  typedef struct packed {
    logic [3:0]  idx;
    logic [47:0] sk;
  } exp_t;

  localparam int PC1_T [56] = '{
    57, 49, 41, 33, 25, 17, 9,  1, 58, 50, 42, 34, 26, 18,
    10, 2,  59, 51, 43, 35, 27, 19, 11, 3, 60, 52, 44, 36,
    63, 55, 47, 39, 31, 23, 15, 7, 62, 54, 46, 38, 30, 22,
    14, 6,  61, 53, 45, 37, 29, 21, 13, 5, 28, 20, 12, 4
  };
  localparam int PC2_T [48] = '{
    14, 17, 11, 24, 1,  5,  3,  28, 15, 6,  21, 10,
    23, 19, 12, 4,  26, 8,  16, 7,  27, 20, 13, 2,
    41, 52, 31, 37, 47, 55, 30, 40, 51, 45, 33, 48,
    44, 49, 39, 56, 34, 53, 46, 42, 50, 36, 29, 32
  };
  localparam int SH_T [16] = '{1, 1, 2, 2, 2, 2, 2, 2, 1, 2, 2, 2, 2, 2, 2, 1};

  logic        clk;
  logic        rst;
  int          checks;
  int          failures;
  exp_t        sb_q [$];
  logic [47:0] mdl_k [16];
  logic        exp_perr;

  des_key_schedule_dec_if ks_if ();

  des_key_schedule_dec dut (
    .clk (clk),
    .rst (rst),
    .ks  (ks_if)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Forward DES schedule: mdl_k[r] holds K(r+1).
  task automatic model_schedule(input logic [63:0] key);
    logic [27:0] c;
    logic [27:0] d;
    logic [55:0] cd;
    logic [47:0] k;
    for (int i = 0; i < 28; i++) c[27-i] = key[64-PC1_T[i]];
    for (int i = 0; i < 28; i++) d[27-i] = key[64-PC1_T[28+i]];
    for (int r = 0; r < 16; r++) begin
      for (int s = 0; s < SH_T[r]; s++) begin
        c = {c[26:0], c[27]};
        d = {d[26:0], d[27]};
      end
      cd = {c, d};
      for (int i = 0; i < 48; i++) k[47-i] = cd[56-PC2_T[i]];
      mdl_k[r] = k;
    end
  endtask

  function automatic logic model_parity(input logic [63:0] key);
    logic bad;
    bad = 1'b0;
`ifdef DES_KS_PARITY_CHECK_EN
    for (int b = 0; b < 8; b++) bad = bad | ~(^key[8*b +: 8]);
`endif
    return bad;
  endfunction

  // Offer a key, wait (bounded) for key_ready, queue its expected subkeys, cross the accept edge.
  task automatic send_key(input logic [63:0] key, input bit hold, output int waited);
    exp_t e;
    ks_if.key_in    = key;
    ks_if.key_valid = 1'b1;
    waited = 0;
    while (ks_if.key_ready !== 1'b1 && waited < 50) begin
      @(posedge clk); #1;
      waited++;
    end
    check("key_ready_wait", ks_if.key_ready, 1);
    model_schedule(key);
    for (int i = 15; i >= 0; i--) begin
      e.idx = 4'(i);
      e.sk  = mdl_k[i];
      sb_q.push_back(e);
    end
    exp_perr = model_parity(key);
    @(posedge clk); #1;
    if (!hold) ks_if.key_valid = 1'b0;
    check("latency_valid", ks_if.subkey_valid, 1);
    check("latency_idx", ks_if.subkey_idx, 15);
  endtask

  // Consume up to n_hs subkeys. poke: 0 = key_valid low, 1 = random key pokes, 2 = leave key inputs.
  task automatic run_schedule(input int ready_pct, input int poke, input int n_hs,
                              output logic [47:0] last_sk, output int cycles);
    int          hs;
    bit          stalled;
    logic [47:0] prev_sk;
    logic [3:0]  prev_idx;
    exp_t        e;
    hs = 0; stalled = 1'b0; cycles = 0; last_sk = '0; prev_sk = '0; prev_idx = '0;
    while (hs < n_hs && cycles < 400) begin
      check("emit_valid", ks_if.subkey_valid, 1);
      check("emit_key_ready", ks_if.key_ready, 0);
      check("parity_err", ks_if.key_parity_err, exp_perr);
      if (stalled) begin
        check("stall_subkey", ks_if.subkey, prev_sk);
        check("stall_idx", ks_if.subkey_idx, prev_idx);
      end
      if (poke == 1) begin
        ks_if.key_valid = 1'($urandom_range(1));
        ks_if.key_in    = {$urandom, $urandom};
      end else if (poke == 0) begin
        ks_if.key_valid = 1'b0;
      end
      ks_if.subkey_ready = ($urandom_range(99) < ready_pct);
      if (ks_if.subkey_ready && ks_if.subkey_valid && sb_q.size() > 0) begin
        e = sb_q.pop_front();
        check("sb_idx", ks_if.subkey_idx, e.idx);
        check("sb_subkey", ks_if.subkey, e.sk);
        last_sk = ks_if.subkey;
        hs++;
        stalled = 1'b0;
      end else begin
        stalled  = 1'b1;
        prev_sk  = ks_if.subkey;
        prev_idx = ks_if.subkey_idx;
      end
      @(posedge clk); #1;
      cycles++;
    end
    ks_if.subkey_ready = 1'b0;
    if (poke != 2) ks_if.key_valid = 1'b0;
    check("hs_count", hs, n_hs);
  endtask

  task automatic end_checks();
    check("done_key_ready", ks_if.key_ready, 1);
    check("done_valid", ks_if.subkey_valid, 0);
    check("done_sb_drained", sb_q.size(), 0);
    check("done_parity_hold", ks_if.key_parity_err, exp_perr);
  endtask

  initial begin
    logic [47:0] last_sk;
    int          cyc;
    int          waited;
    logic [63:0] rk;

    checks = 0; failures = 0; exp_perr = 1'b0;
    rst = 1'b1;
    ks_if.key_in = '0; ks_if.key_valid = 1'b0; ks_if.subkey_ready = 1'b0;

    // Reset state, with a key offered during reset that must not be taken.
    repeat (2) @(posedge clk);
    ks_if.key_valid = 1'b1;
    ks_if.key_in    = 64'h133457799BBCDFF1;
    @(posedge clk); #1;
    check("rst_key_ready", ks_if.key_ready, 0);
    check("rst_valid", ks_if.subkey_valid, 0);
    check("rst_subkey", ks_if.subkey, 0);
    check("rst_idx", ks_if.subkey_idx, 0);
    check("rst_parity", ks_if.key_parity_err, 0);
    ks_if.key_valid = 1'b0;
    rst = 1'b0;
    @(posedge clk); #1;
    check("idle_key_ready", ks_if.key_ready, 1);
    check("idle_valid", ks_if.subkey_valid, 0);

    // Known-answer key, consumer always ready.
    send_key(64'h133457799BBCDFF1, 1'b0, waited);
    check("kat_k16", ks_if.subkey, 48'hCB3D8B0E17F5);
    run_schedule(100, 0, 16, last_sk, cyc);
    check("kat_k1", last_sk, 48'h1B02EFFC7072);
    check("kat_cycles", cyc, 16);
    end_checks();

    // Random key with ~50% back-pressure and key pokes during EMIT.
    rk = {$urandom, $urandom};
    send_key(rk, 1'b0, waited);
    run_schedule(50, 1, 16, last_sk, cyc);
    end_checks();

    // Reset after the 5th handshake abandons the schedule.
    send_key(64'h0E329232EA6D0D73, 1'b0, waited);
    run_schedule(100, 0, 5, last_sk, cyc);
    rst = 1'b1;
    @(posedge clk); #1;
    check("midrst_valid", ks_if.subkey_valid, 0);
    check("midrst_idx", ks_if.subkey_idx, 0);
    check("midrst_subkey", ks_if.subkey, 0);
    check("midrst_parity", ks_if.key_parity_err, 0);
    rst = 1'b0;
    sb_q.delete();
    exp_perr = 1'b0;
    @(posedge clk); #1;
    check("midrst_key_ready", ks_if.key_ready, 1);
    rk = {$urandom, $urandom};
    send_key(rk, 1'b0, waited);
    run_schedule(60, 0, 16, last_sk, cyc);
    end_checks();

    // All-zero key (even parity in every byte) and the odd-parity 0x01 pattern.
    send_key(64'h0000000000000000, 1'b0, waited);
    run_schedule(70, 0, 16, last_sk, cyc);
    end_checks();
    send_key(64'h0101010101010101, 1'b0, waited);
    run_schedule(100, 0, 16, last_sk, cyc);
    check("ones_k1_zero", last_sk, 0);
    end_checks();

    // Back-to-back keys with key_valid held high throughout.
    send_key(64'hFEDCBA9876543210, 1'b1, waited);
    ks_if.key_in = 64'h0123456789ABCDEF;
    run_schedule(100, 2, 16, last_sk, cyc);
    check("b2b_first_cycles", cyc, 16);
    end_checks();
    send_key(64'h0123456789ABCDEF, 1'b0, waited);
    check("b2b_no_wait", waited, 0);
    run_schedule(100, 0, 16, last_sk, cyc);
    end_checks();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/des_key_schedule_dec.md
# des_key_schedule_dec

Iterative DES decryption key-schedule generator. It accepts one 64-bit DES key and streams the 16 round subkeys in decryption order: K16 first, K1 last. Internally it applies PC-1, then right rotations of the C/D halves, then PC-2. It sits beside the round datapath and feeds the subkey port of the pipelined/iterative decrypt path, which consumes the same 48-bit subkeys in reverse order.

## Interface

Parameters: none.

Ports:
- `clk`  in  1  — single clock; all state changes on the rising edge.
- `rst`  in  1  — reset; synchronous, active-high.
- `key_in`  in  [0:63]  — DES key, DES bit 1 = index 0; parity bits 7, 15, …, 63 are dropped by PC-1.
- `key_valid`  in  1  — key_in is valid.
- `key_ready`  out  1  — block can accept a key.
- `subkey`  out  [0:47]  — current round subkey, PC-2 order.
- `subkey_idx`  out  [3:0]  — round number minus 1 (15 = K16 … 0 = K1).
- `subkey_valid`  out  1  — subkey/subkey_idx are valid.
- `subkey_ready`  in  1  — consumer accepts the subkey.
- `key_parity_err`  out  1  — odd-parity violation on the accepted key (see Configuration).

## Operation

- State machine has two states:
  - IDLE: key_ready=1, subkey_valid=0.
  - EMIT: key_ready=0, subkey_valid=1.
- Key handshake: `key_valid && key_ready` loads CD ← PC1(key_in) (56 b, C = [0:27], D = [28:55]), sets idx ← 15, and goes to EMIT.
- Subkey output: subkey = PC2(CD), combinational from the CD register. subkey_idx = idx.
- Subkey handshake (`subkey_valid && subkey_ready`):
  - If idx = 0: go to IDLE; CD and idx hold.
  - Otherwise: rotate C and D right by shift(idx+1) and set idx ← idx−1.
  - shift(r) = 1 for r ∈ {1, 2, 9, 16}, else 2.
- K16 = PC2(PC1(key)) with no rotation, because the total encrypt rotation is 28.
- Sequence of rotations after each of K16…K2: 1,2,2,2,2,2,2,1,2,2,2,2,2,2,1.
- subkey and subkey_idx stay stable while `subkey_valid && !subkey_ready`.
- A new key is never accepted in EMIT. key_valid is ignored there and the upstream holds.

## Timing

- Reset values, applied while rst is high and in the cycle after: state=IDLE, CD=0, idx=0, key_parity_err=0.
  - Outputs: key_ready=0 while rst=1, then 1; subkey_valid=0; subkey=0; subkey_idx=0.
- Latency: key accepted at edge N → K16 valid in the cycle after N.
- Throughput: with subkey_ready held high, K16…K1 occupy 16 consecutive cycles. key_ready is 1 in the cycle after the K1 handshake.
- Key-to-key turnaround is at least 17 cycles. There is no overlap of the last handshake with a new key accept.
- Back-pressure: any number of stall cycles per subkey; the output holds.
- rst asserted mid-schedule: the schedule is abandoned and the reset values apply on the next edge. No further subkeys are emitted for that key.
- Simultaneous rst and key_valid: reset wins and the key is not accepted.

## Configuration

- `DES_KS_PARITY_CHECK_EN` defined:
  - On key accept, key_parity_err is registered as the OR over the 8 bytes of (byte has even parity).
  - It holds through EMIT and clears on the next key accept or on rst.
  - The key is still processed normally.
- Not defined: key_parity_err is constant 0 and no parity logic is built. The port always exists.

## Structure

- Shared package `des_pkg`:
  - typedefs `des_key_t` [0:63], `des_cd_t` [0:55], `des_subkey_t` [0:47].
  - constants `PC1_TABLE` (56 indices) and `PC2_TABLE` (48 indices).
  - constant `KS_SHIFT` (16 entries, 1/2).
- One sub-module, `des_pc2`: combinational 56→48 permutation, instantiated once on the CD register. PC-1 and the rotations stay inline.

## Test plan

- Key 0x133457799BBCDFF1, subkey_ready=1:
  - cycle 1: idx=15, subkey=0xCB3D8B0E17F5.
  - cycle 16: idx=0, subkey=0x1B02EFFC7072.
  - key_ready=1 in cycle 17.
- Same key, compared against the reference-model forward schedule: the emitted sequence equals K16…K1 exactly; idx decrements 15→0 with no gaps.
- Random subkey_ready stalls (≈50%): subkey/idx stable during stalls; exactly 16 handshakes; key_valid pulses during EMIT are not accepted.
- rst pulsed after the 5th handshake: next cycle subkey_valid=0, idx=0, subkey=0. A fresh key then produces a full 16-subkey sequence.
- Key 0x0000000000000000:
  - With `DES_KS_PARITY_CHECK_EN`: key_parity_err=1 through EMIT.
  - Key 0x0101010101010101: key_parity_err=0; all subkeys 0.
  - Without the macro: key_parity_err stays 0 for both keys.
- Two keys back-to-back with key_valid held high: the second key is accepted only in the cycle after K1 of the first, and its K16 follows one cycle later.
